// File: rtl/cam_ctrl_seq_if.sv
// cam_ctrl_seq_if
//
// Bundles the camera-control sequencer's operator, configuration-engine
// and sensor-pin signals into one interface.
//
// Signals:
//   i_btn_cfg      debounced reconfiguration button level
//   i_btn_freeze   debounced freeze-frame button level
//   i_cfg_done     done indication from the register-configuration engine
//   i_frame_start  one-cycle pulse at the start of each frame
//   o_cam_rstn     sensor RESET# (active low)
//   o_cam_pwdn     sensor PWDN
//   o_cfg_start    one-cycle start pulse to the configuration engine
//   o_capture_en   enable for the pixel capture/write path
//   o_busy         high while the power-up / configuration sequence runs
//   o_err          configuration timeout flag
//
// Modports:
//   slave  - the sequencer (consumes i_*, drives o_*)
//   master - the surrounding system (drives i_*, consumes o_*)
interface cam_ctrl_seq_if;
    logic i_btn_cfg;
    logic i_btn_freeze;
    logic i_cfg_done;
    logic i_frame_start;
    logic o_cam_rstn;
    logic o_cam_pwdn;
    logic o_cfg_start;
    logic o_capture_en;
    logic o_busy;
    logic o_err;

    modport slave (
        input  i_btn_cfg,
        input  i_btn_freeze,
        input  i_cfg_done,
        input  i_frame_start,
        output o_cam_rstn,
        output o_cam_pwdn,
        output o_cfg_start,
        output o_capture_en,
        output o_busy,
        output o_err
    );

    modport master (
        output i_btn_cfg,
        output i_btn_freeze,
        output i_cfg_done,
        output i_frame_start,
        input  o_cam_rstn,
        input  o_cam_pwdn,
        input  o_cfg_start,
        input  o_capture_en,
        input  o_busy,
        input  o_err
    );
endinterface

// File: rtl/cam_ctrl_seq.sv
// cam_ctrl_seq
//
// Power-up and operator-control sequencer for the OV7670 camera path.
// Holds the sensor in reset, waits out its boot time, kicks the register
// configuration engine, waits for it to finish (with a timeout), and then
// gates pixel capture on frame boundaries. Two debounced buttons are
// edge-detected here: one requests a full re-init, the other toggles
// freeze-frame.
//
// Parameters:
//   RST_CYCLES   clocks o_cam_rstn is held low per sequence
//   BOOT_CYCLES  clocks waited after reset release before configuration
//   CFG_TIMEOUT  maximum clocks spent waiting for configuration done
//
// Ports:
//   i_clk   system clock
//   i_rst   synchronous active-high reset
//   bus     cam_ctrl_seq_if.slave (buttons, cfg handshake, frame pulse,
//           sensor pins, capture enable, busy/error status)
//
// All outputs are registered.
module cam_ctrl_seq #(
    parameter int RST_CYCLES  = 240_000,
    parameter int BOOT_CYCLES = 240_000,
    parameter int CFG_TIMEOUT = 24_000_000
) (
    input  logic           i_clk,
    input  logic           i_rst,
    cam_ctrl_seq_if.slave  bus
);

    localparam int MAX_A = (RST_CYCLES > BOOT_CYCLES) ? RST_CYCLES : BOOT_CYCLES;
    localparam int MAX_P = (MAX_A > CFG_TIMEOUT) ? MAX_A : CFG_TIMEOUT;
    localparam int CW    = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] BOOT_LAST = CW'(BOOT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(CFG_TIMEOUT - 1);

    typedef enum logic [2:0] {
        RESET_HOLD,
        PWR_WAIT,
        CFG_START,
        CFG_WAIT,
        RUN,
        ERR
    } state_t;

    // Button edge detection: bit 0 = cfg, bit 1 = freeze.
    localparam int NBTN = 2;
    localparam int CFG_B = 0;
    localparam int FRZ_B = 1;

    logic [NBTN-1:0] btn;
    logic [NBTN-1:0] btn_prev_reg;
    logic [NBTN-1:0] btn_edge;

    assign btn = {bus.i_btn_freeze, bus.i_btn_cfg};

    // Previous levels load 1 on reset so a button held through reset
    // does not register as a fresh press.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            btn_prev_reg <= '1;
        end else begin
            btn_prev_reg <= btn;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NBTN; gi++) begin : g_edge
            assign btn_edge[gi] = btn[gi] & ~btn_prev_reg[gi];
        end
    endgenerate

    state_t         state_reg,  state_next;
    logic [CW-1:0]  cnt_reg,    cnt_next;
    logic           freeze_reg, freeze_next;
    logic           rstn_reg,   rstn_next;
    logic           pwdn_reg;
    logic           start_reg,  start_next;
    logic           cap_reg,    cap_next;
    logic           busy_reg,   busy_next;
    logic           err_reg,    err_next;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg  <= RESET_HOLD;
            cnt_reg    <= '0;
            freeze_reg <= 1'b0;
            rstn_reg   <= 1'b0;
            pwdn_reg   <= 1'b0;
            start_reg  <= 1'b0;
            cap_reg    <= 1'b0;
            busy_reg   <= 1'b1;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            freeze_reg <= freeze_next;
            rstn_reg   <= rstn_next;
            pwdn_reg   <= 1'b0;
            start_reg  <= start_next;
            cap_reg    <= cap_next;
            busy_reg   <= busy_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg + CW'(1);
        freeze_next = freeze_reg;
        cap_next    = cap_reg;
        rstn_next   = 1'b1;
        start_next  = 1'b0;
        busy_next   = 1'b1;
        err_next    = 1'b0;

        case (state_reg)
            RESET_HOLD: begin
                if (cnt_reg == RST_LAST) state_next = PWR_WAIT;
            end
            PWR_WAIT: begin
                if (cnt_reg == BOOT_LAST) state_next = CFG_START;
            end
            CFG_START: begin
                state_next = CFG_WAIT;
            end
            CFG_WAIT: begin
                // Done takes priority over a simultaneous timeout.
                if (bus.i_cfg_done) begin
                    state_next = RUN;
                end else if (cnt_reg == TO_LAST) begin
                    state_next = ERR;
                end
            end
            RUN: begin
                if (btn_edge[CFG_B]) begin
                    // Re-init wins over a same-cycle freeze press.
                    state_next  = RESET_HOLD;
                    freeze_next = 1'b0;
                end else begin
                    if (btn_edge[FRZ_B]) freeze_next = ~freeze_reg;
                    // A frame starting alongside a freeze press uses the
                    // already-toggled request.
                    if (bus.i_frame_start) cap_next = ~freeze_next;
                end
            end
            ERR: begin
                if (btn_edge[CFG_B]) state_next = RESET_HOLD;
            end
            default: begin
                state_next = RESET_HOLD;
            end
        endcase

        // Shared counter restarts on every state change and idles at zero
        // in the states that do not time anything.
        if (state_next != state_reg || state_next == RUN || state_next == ERR) begin
            cnt_next = '0;
        end

        // Registered outputs are decoded from the next state so they are
        // valid in the same cycle the state becomes current.
        rstn_next  = (state_next != RESET_HOLD);
        start_next = (state_next == CFG_START);
        busy_next  = (state_next != RUN) && (state_next != ERR);
        err_next   = (state_next == ERR);
        if (state_next != RUN) cap_next = 1'b0;
    end

    assign bus.o_cam_rstn   = rstn_reg;
    assign bus.o_cam_pwdn   = pwdn_reg;
    assign bus.o_cfg_start  = start_reg;
    assign bus.o_capture_en = cap_reg;
    assign bus.o_busy       = busy_reg;
    assign bus.o_err        = err_reg;

endmodule
